// File: rtl/sprite_anim_seq_pkg.sv
// ---------------------------------------------------------------------------
// sprite_anim_seq_pkg
// Shared definitions for the sprite animation sequencer:
//   - entity codes of the pixel stream
//   - animation state encoding (also the anim_state output encoding)
//   - joystick direction encoding
//   - sprite-sheet column/row origins of every animation frame
// No ports; imported by sprite_anim_seq and sprite_coord_lut.
// ---------------------------------------------------------------------------
package sprite_anim_seq_pkg;

    typedef logic [17:0] coord_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DYING = 2'd1,
        ST_DEAD  = 2'd2
    } anim_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Entity codes; ghosts occupy ENT_GHOST_BASE .. ENT_GHOST_BASE+NUM_GHOSTS-1
    localparam logic [6:0] ENT_PACMAN     = 7'd1;
    localparam logic [6:0] ENT_BACKGROUND = 7'd2;
    localparam logic [6:0] ENT_GHOST_BASE = 7'd3;

    // All animation frames are 16 pixels apart on the sheet
    localparam coord_t SPRITE_PITCH      = 18'd16;
    localparam int     SPRITE_PITCH_LOG2 = 4;

    // Pacman, running
    localparam coord_t PAC_CLOSED_COL    = 18'd261;
    localparam coord_t PAC_CLOSED_ROW    = 18'd0;
    localparam coord_t PAC_OPEN_COL      = 18'd229;
    localparam coord_t PAC_OPEN_LEFT_COL = 18'd228;
    localparam coord_t PAC_OPEN_ROW_UP   = 18'd31;
    localparam coord_t PAC_OPEN_ROW_LEFT = 18'd16;
    localparam coord_t PAC_OPEN_ROW_DOWN = 18'd49;
    localparam coord_t PAC_OPEN_ROW_RGT  = 18'd0;
    localparam coord_t PAC_HALF_COL      = 18'd245;
    localparam coord_t PAC_HALF_ROW_UP   = 18'd32;
    localparam coord_t PAC_HALF_ROW_LEFT = 18'd16;
    localparam coord_t PAC_HALF_ROW_DOWN = 18'd47;
    localparam coord_t PAC_HALF_ROW_RGT  = 18'd0;

    // Pacman, death animation
    localparam coord_t PAC_DYING_COL     = 18'd276;
    localparam coord_t PAC_DEAD_COL      = 18'd460;
    localparam coord_t PAC_DEATH_ROW     = 18'd1;

    // Ghosts
    localparam coord_t GHOST_ROW_BASE    = 18'd65;
    localparam coord_t GHOST_COL_UP      = 18'd293;
    localparam coord_t GHOST_COL_LEFT    = 18'd261;
    localparam coord_t GHOST_COL_DOWN    = 18'd325;
    localparam coord_t GHOST_COL_RIGHT   = 18'd229;
    localparam coord_t FRIGHT_COL        = 18'd357;
    localparam coord_t FRIGHT_ROW        = 18'd65;
    localparam coord_t FLASH_COL_OFS     = 18'd32;

    function automatic coord_t pac_open_row(input dir_t d);
        coord_t r;
        case (d)
            DIR_UP:   r = PAC_OPEN_ROW_UP;
            DIR_LEFT: r = PAC_OPEN_ROW_LEFT;
            DIR_DOWN: r = PAC_OPEN_ROW_DOWN;
            default:  r = PAC_OPEN_ROW_RGT;
        endcase
        return r;
    endfunction

    function automatic coord_t pac_half_row(input dir_t d);
        coord_t r;
        case (d)
            DIR_UP:   r = PAC_HALF_ROW_UP;
            DIR_LEFT: r = PAC_HALF_ROW_LEFT;
            DIR_DOWN: r = PAC_HALF_ROW_DOWN;
            default:  r = PAC_HALF_ROW_RGT;
        endcase
        return r;
    endfunction

    function automatic coord_t ghost_dir_col(input dir_t d);
        coord_t c;
        case (d)
            DIR_UP:   c = GHOST_COL_UP;
            DIR_LEFT: c = GHOST_COL_LEFT;
            DIR_DOWN: c = GHOST_COL_DOWN;
            default:  c = GHOST_COL_RIGHT;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sprite_anim_seq_coord_lut.sv
// ---------------------------------------------------------------------------
// sprite_coord_lut
// Maps (entity, direction, animation state, counters) to the sheet origin
// (col,row) of the sprite frame to draw. Purely combinational.
// Ports:
//   entity        in  7   entity code of the current pixel
//   direction     in  2   movement direction (dir_t encoding)
//   anim_state    in  2   sequencer state (anim_state_t encoding)
//   walk_cnt      in  4   walk animation phase
//   death_cnt     in  DW  death animation step
//   fright_timer  in  FW  frightened frames remaining
//   col, row      out 18  sheet origin of the selected frame
//   blank         out 1   nothing to draw: sheet address must be forced to 0
// ---------------------------------------------------------------------------
module sprite_coord_lut
    import sprite_anim_seq_pkg::*;
#(
    parameter int NUM_GHOSTS   = 4,
    parameter int FLASH_FRAMES = 120,
    parameter int DEATH_W      = 4,
    parameter int FRIGHT_W     = 9
)(
    input  logic [6:0]          entity,
    input  logic [1:0]          direction,
    input  logic [1:0]          anim_state,
    input  logic [3:0]          walk_cnt,
    input  logic [DEATH_W-1:0]  death_cnt,
    input  logic [FRIGHT_W-1:0] fright_timer,
    output logic [17:0]         col,
    output logic [17:0]         row,
    output logic                blank
);

    localparam logic [6:0]          GHOST_LIMIT = 7'(ENT_GHOST_BASE + NUM_GHOSTS);
    localparam logic [FRIGHT_W-1:0] FLASH_CMP   = FRIGHT_W'(FLASH_FRAMES);

    anim_state_t state_e;
    dir_t        dir_e;
    logic [6:0]  ghost_idx;
    logic        is_ghost;
    logic        frightened;
    logic        flashing;
    coord_t      stride;

    assign state_e    = anim_state_t'(anim_state);
    assign dir_e      = dir_t'(direction);
    assign ghost_idx  = entity - ENT_GHOST_BASE;
    assign is_ghost   = (entity >= ENT_GHOST_BASE) && (entity < GHOST_LIMIT);
    assign frightened = (fright_timer != '0);
    // Flashing alternates blue/white on walk_cnt[3] once the timer runs low
    assign flashing   = (fright_timer <= FLASH_CMP) && walk_cnt[3];
    // Two-frame leg wiggle shared by all ghost sprites
    assign stride     = walk_cnt[2] ? SPRITE_PITCH : '0;

    always_comb begin
        col   = '0;
        row   = '0;
        blank = 1'b1;
        if (entity == ENT_PACMAN) begin
            blank = 1'b0;
            case (state_e)
                ST_RUN: begin
                    // walk_cnt[3:2]: 00 closed, 10 open, 01/11 half open
                    case (walk_cnt[3:2])
                        2'b00: begin
                            col = PAC_CLOSED_COL;
                            row = PAC_CLOSED_ROW;
                        end
                        2'b10: begin
                            col = (dir_e == DIR_LEFT) ? PAC_OPEN_LEFT_COL : PAC_OPEN_COL;
                            row = pac_open_row(dir_e);
                        end
                        default: begin
                            col = PAC_HALF_COL;
                            row = pac_half_row(dir_e);
                        end
                    endcase
                end
                ST_DYING: begin
                    col = PAC_DYING_COL + (coord_t'(death_cnt) << SPRITE_PITCH_LOG2);
                    row = PAC_DEATH_ROW;
                end
                ST_DEAD: begin
                    col = PAC_DEAD_COL;
                    row = PAC_DEATH_ROW;
                end
                default: blank = 1'b1;
            endcase
        end else if (is_ghost && (state_e == ST_RUN)) begin
            blank = 1'b0;
            if (frightened) begin
                row = FRIGHT_ROW;
                col = FRIGHT_COL + stride + (flashing ? FLASH_COL_OFS : '0);
            end else begin
                row = GHOST_ROW_BASE + (coord_t'(ghost_idx) << SPRITE_PITCH_LOG2);
                col = ghost_dir_col(dir_e) + stride;
            end
        end
    end

endmodule

// File: rtl/sprite_anim_seq.sv
// ---------------------------------------------------------------------------
// sprite_anim_seq
// Animation sequencer for the maze sprites: walk phase counter, pacman
// death FSM, ghost frightened timer, and the sprite-sheet read address of
// the pixel currently being drawn.
// Ports:
//   frame_clk     in  1   frame clock
//   Reset         in  1   synchronous, active-high reset
//   pause         in  1   freezes walk phase and frightened timer
//   lose_game     in  1   level: player caught
//   fright_start  in  1   pulse: power pellet eaten
//   entity        in  7   entity code of the pixel being drawn
//   direction     in  2   0 up, 1 left, 2 down, 3 right
//   spriteAddrX   in  10  sprite-relative pixel X
//   spriteAddrY   in  10  sprite-relative pixel Y
//   sprite_addr   out 18  sheet read address (combinational)
//   anim_state    out 2   0 RUN, 1 DYING, 2 DEAD
//   fright_active out 1   frightened timer nonzero
//   death_done    out 1   one-cycle pulse after DYING->DEAD
//
// state | meaning
// RUN   | normal play, walk phase advancing
// DYING | death animation, death_cnt stepping to DEATH_FRAMES
// DEAD  | final death frame, waiting for lose_game to drop
// ---------------------------------------------------------------------------
module sprite_anim_seq
    import sprite_anim_seq_pkg::*;
#(
    parameter int NUM_GHOSTS    = 4,
    parameter int SHEET_W_LOG2  = 9,
    parameter int DEATH_FRAMES  = 11,
    parameter int FRIGHT_FRAMES = 360,
    parameter int FLASH_FRAMES  = 120
)(
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        pause,
    input  logic        lose_game,
    input  logic        fright_start,
    input  logic [6:0]  entity,
    input  logic [1:0]  direction,
    input  logic [9:0]  spriteAddrX,
    input  logic [9:0]  spriteAddrY,
    output logic [17:0] sprite_addr,
    output logic [1:0]  anim_state,
    output logic        fright_active,
    output logic        death_done
);

    localparam int DEATH_W  = (DEATH_FRAMES  < 1) ? 1 : $clog2(DEATH_FRAMES + 1);
    localparam int FRIGHT_W = (FRIGHT_FRAMES < 1) ? 1 : $clog2(FRIGHT_FRAMES + 1);

    localparam logic [DEATH_W-1:0]  DEATH_LAST  = DEATH_W'(DEATH_FRAMES);
    localparam logic [FRIGHT_W-1:0] FRIGHT_LOAD = FRIGHT_W'(FRIGHT_FRAMES);

    anim_state_t         state;
    logic [3:0]          walk_cnt;
    logic [DEATH_W-1:0]  death_cnt;
    logic [FRIGHT_W-1:0] fright_timer;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            state        <= ST_RUN;
            walk_cnt     <= '0;
            death_cnt    <= '0;
            fright_timer <= '0;
            death_done   <= 1'b0;
        end else begin
            death_done <= 1'b0;

            case (state)
                ST_RUN: begin
                    if (!pause) begin
                        walk_cnt <= walk_cnt + 4'd1;
                    end
                    if (lose_game) begin
                        state     <= ST_DYING;
                        death_cnt <= '0;
                    end
                end
                ST_DYING: begin
                    // Death animation deliberately ignores pause
                    if (death_cnt == DEATH_LAST) begin
                        state      <= ST_DEAD;
                        death_done <= 1'b1;
                    end else begin
                        death_cnt <= death_cnt + DEATH_W'(1);
                    end
                end
                ST_DEAD: begin
                    if (!lose_game) begin
                        state     <= ST_RUN;
                        walk_cnt  <= '0;
                        death_cnt <= '0;
                    end
                end
                default: state <= ST_RUN;
            endcase

            // lose_game wins over a same-edge pellet; pellets outside RUN are dropped
            if (lose_game || (state == ST_DEAD)) begin
                fright_timer <= '0;
            end else if (fright_start && (state == ST_RUN)) begin
                fright_timer <= FRIGHT_LOAD;
            end else if ((fright_timer != '0) && !pause) begin
                fright_timer <= fright_timer - FRIGHT_W'(1);
            end
        end
    end

    assign anim_state    = state;
    assign fright_active = (fright_timer != '0);

    logic [17:0] lut_col;
    logic [17:0] lut_row;
    logic        lut_blank;
    logic [17:0] x_sum;
    logic [17:0] y_sum;

    sprite_coord_lut #(
        .NUM_GHOSTS   (NUM_GHOSTS),
        .FLASH_FRAMES (FLASH_FRAMES),
        .DEATH_W      (DEATH_W),
        .FRIGHT_W     (FRIGHT_W)
    ) u_coord_lut (
        .entity       (entity),
        .direction    (direction),
        .anim_state   (state),
        .walk_cnt     (walk_cnt),
        .death_cnt    (death_cnt),
        .fright_timer (fright_timer),
        .col          (lut_col),
        .row          (lut_row),
        .blank        (lut_blank)
    );

    // 18-bit arithmetic gives the required modulo-2^18 truncation for free
    assign x_sum       = lut_col + 18'(spriteAddrX);
    assign y_sum       = lut_row + 18'(spriteAddrY);
    assign sprite_addr = lut_blank ? '0 : (x_sum + (y_sum << SHEET_W_LOG2));

endmodule

// File: tb/tb_sprite_anim_seq.sv
// Bench for sprite_anim_seq: a reference model predicts post-edge outputs,
// which are queued before each edge and popped/compared after it.
module tb_sprite_anim_seq;

    localparam int NG  = 4;
    localparam int SHW = 9;
    localparam int DF  = 11;
    localparam int FF  = 360;
    localparam int FL  = 120;

    logic        frame_clk = 1'b0;
    logic        Reset, pause, lose_game, fright_start;
    logic [6:0]  entity;
    logic [1:0]  direction;
    logic [9:0]  spriteAddrX, spriteAddrY;
    logic [17:0] sprite_addr;
    logic [1:0]  anim_state;
    logic        fright_active, death_done;

    sprite_anim_seq #(
        .NUM_GHOSTS(NG), .SHEET_W_LOG2(SHW), .DEATH_FRAMES(DF),
        .FRIGHT_FRAMES(FF), .FLASH_FRAMES(FL)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .pause(pause),
        .lose_game(lose_game), .fright_start(fright_start),
        .entity(entity), .direction(direction),
        .spriteAddrX(spriteAddrX), .spriteAddrY(spriteAddrY),
        .sprite_addr(sprite_addr), .anim_state(anim_state),
        .fright_active(fright_active), .death_done(death_done)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic [17:0] addr;
        logic [1:0]  st;
        logic        fa;
        logic        done;
    } exp_t;

    typedef struct {
        logic [6:0]  ent;
        logic [1:0]  dir;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [17:0] addr;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[11];

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int m_st = 0, m_walk = 0, m_death = 0, m_tmr = 0, m_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dir_col(input int d);
        case (d)
            0: return 293;
            1: return 261;
            2: return 325;
            default: return 229;
        endcase
    endfunction

    // Expected sheet address from model state and current inputs
    function automatic logic [17:0] ref_addr();
        int ent, d, col, row, total;
        ent = int'(entity);
        d   = int'(direction);
        if (ent == 1) begin
            if (m_st == 0) begin
                if (m_walk < 4) begin
                    col = 261; row = 0;
                end else if (m_walk >= 8 && m_walk <= 11) begin
                    col = (d == 1) ? 228 : 229;
                    row = (d == 0) ? 31 : (d == 1) ? 16 : (d == 2) ? 49 : 0;
                end else begin
                    col = 245;
                    row = (d == 0) ? 32 : (d == 1) ? 16 : (d == 2) ? 47 : 0;
                end
            end else if (m_st == 1) begin
                col = 276 + 16 * m_death; row = 1;
            end else begin
                col = 460; row = 1;
            end
        end else if (ent >= 3 && ent < 3 + NG && m_st == 0) begin
            if (m_tmr != 0) begin
                row = 65;
                col = 357 + 16 * ((m_walk / 4) % 2);
                if (m_tmr <= FL && m_walk >= 8) col += 32;
            end else begin
                row = 65 + 16 * (ent - 3);
                col = dir_col(d) + 16 * ((m_walk / 4) % 2);
            end
        end else begin
            return 18'd0;
        end
        total = (int'(spriteAddrX) + col) + ((int'(spriteAddrY) + row) << SHW);
        return 18'(total);
    endfunction

    // Advance the model across one edge using the currently driven inputs
    task automatic model_edge();
        int ns, nw, nd, nt, ndone;
        if (Reset) begin
            ns = 0; nw = 0; nd = 0; nt = 0; ndone = 0;
        end else begin
            ns = m_st; nw = m_walk; nd = m_death; nt = m_tmr; ndone = 0;
            if (m_st == 0 && !pause) nw = (m_walk + 1) % 16;
            if (m_st == 0 && lose_game) begin ns = 1; nd = 0; end
            if (m_st == 1) begin
                if (m_death == DF) begin ns = 2; ndone = 1; end
                else nd = m_death + 1;
            end
            if (m_st == 2 && !lose_game) begin ns = 0; nw = 0; nd = 0; end
            if (m_tmr > 0 && !pause) nt = m_tmr - 1;
            if (fright_start && m_st == 0) nt = FF;
            if (m_st == 2 && !lose_game) nt = 0;
            if (lose_game) nt = 0;
        end
        m_st = ns; m_walk = nw; m_death = nd; m_tmr = nt; m_done = ndone;
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        e.addr = ref_addr();
        e.st   = 2'(m_st);
        e.fa   = (m_tmr != 0);
        e.done = (m_done != 0);
        sb.push_back(e);
        @(posedge frame_clk);
        #1;
        e = sb.pop_front();
        chk("sprite_addr",   32'(sprite_addr),   32'(e.addr));
        chk("anim_state",    32'(anim_state),    32'(e.st));
        chk("fright_active", 32'(fright_active), 32'(e.fa));
        chk("death_done",    32'(death_done),    32'(e.done));
        if (death_done === 1'b1) done_seen++;
    endtask

    initial begin
        Reset = 1'b1; pause = 1'b0; lose_game = 1'b0; fright_start = 1'b0;
        entity = 7'd1; direction = 2'd0; spriteAddrX = '0; spriteAddrY = '0;
        #1;
        step();
        step();
        Reset = 1'b0;

        // Static decode table, walk phase frozen at 0 by pause
        vecs[0]  = '{7'd1,    2'd0, 10'd0,    10'd0,    18'd261};
        vecs[1]  = '{7'd1,    2'd3, 10'd5,    10'd2,    18'd1290};
        vecs[2]  = '{7'd3,    2'd0, 10'd0,    10'd0,    18'd33573};
        vecs[3]  = '{7'd4,    2'd1, 10'd1,    10'd1,    18'd42246};
        vecs[4]  = '{7'd5,    2'd2, 10'd0,    10'd0,    18'd49989};
        vecs[5]  = '{7'd6,    2'd3, 10'd0,    10'd0,    18'd58085};
        vecs[6]  = '{7'd2,    2'd0, 10'd7,    10'd7,    18'd0};
        vecs[7]  = '{7'd7,    2'd0, 10'd3,    10'd3,    18'd0};
        vecs[8]  = '{7'h7F,   2'd1, 10'd9,    10'd9,    18'd0};
        vecs[9]  = '{7'd0,    2'd2, 10'd1,    10'd0,    18'd0};
        vecs[10] = '{7'd6,    2'd3, 10'd1023, 10'd1023, 18'd58596};
        pause = 1'b1;
        for (int i = 0; i < 11; i++) begin
            entity = vecs[i].ent; direction = vecs[i].dir;
            spriteAddrX = vecs[i].x; spriteAddrY = vecs[i].y;
            step();
            chk("table_addr", 32'(sprite_addr), 32'(vecs[i].addr));
        end
        pause = 1'b0;

        // 20 frames from reset: walk_cnt = 4, half-open facing right
        Reset = 1'b1; step(); Reset = 1'b0;
        entity = 7'd1; direction = 2'd3; spriteAddrX = '0; spriteAddrY = '0;
        repeat (20) step();
        chk("walk20_addr", 32'(sprite_addr), 32'd245);

        // Mixed entities/directions/coordinates with occasional pause
        repeat (40) begin
            entity = 7'($urandom_range(0, 9));
            direction = 2'($urandom_range(0, 3));
            spriteAddrX = 10'($urandom_range(0, 1023));
            spriteAddrY = 10'($urandom_range(0, 1023));
            pause = ($urandom_range(0, 4) == 0);
            step();
        end
        pause = 1'b0;

        // Frightened: load, reload, run to expiry through the flash window
        entity = 7'd3; spriteAddrX = '0; spriteAddrY = '0;
        fright_start = 1'b1; step(); fright_start = 1'b0;
        chk("fright_on", 32'(fright_active), 32'd1);
        repeat (50) begin
            entity = 7'($urandom_range(3, 6));
            direction = 2'($urandom_range(0, 3));
            step();
        end
        fright_start = 1'b1; step(); fright_start = 1'b0;
        repeat (359) begin
            entity = 7'($urandom_range(3, 6));
            direction = 2'($urandom_range(0, 3));
            step();
        end
        chk("fright_last_frame", 32'(fright_active), 32'd1);
        step();
        chk("fright_expired", 32'(fright_active), 32'd0);

        // Pause freezes walk phase and timer
        entity = 7'd4;
        fright_start = 1'b1; step(); fright_start = 1'b0;
        repeat (3) step();
        pause = 1'b1;
        repeat (10) step();
        pause = 1'b0;
        repeat (3) step();

        // Pellet and capture on the same edge, then full death sequence
        done_seen = 0;
        entity = 7'd1; direction = 2'd0;
        fright_start = 1'b1; lose_game = 1'b1; step(); fright_start = 1'b0;
        chk("collide_state", 32'(anim_state), 32'd1);
        chk("collide_fright", 32'(fright_active), 32'd0);
        chk("dying_first_addr", 32'(sprite_addr), 32'd788);
        repeat (12) step();
        chk("dead_state", 32'(anim_state), 32'd2);
        chk("dead_pulse", 32'(death_done), 32'd1);
        step();
        chk("dead_addr", 32'(sprite_addr), 32'd972);
        chk("dead_pulse_gone", 32'(death_done), 32'd0);
        lose_game = 1'b0; step();
        chk("revive_state", 32'(anim_state), 32'd0);
        chk("revive_addr", 32'(sprite_addr), 32'd261);
        chk("death_done_pulses", 32'(done_seen), 32'd1);

        // Reset in the middle of the death animation; pellet in DYING ignored
        done_seen = 0;
        lose_game = 1'b1; step(); lose_game = 1'b0;
        fright_start = 1'b1; step(); fright_start = 1'b0;
        chk("dying_pellet_ignored", 32'(fright_active), 32'd0);
        repeat (4) step();
        chk("dying_cnt5_addr", 32'(sprite_addr), 32'(276 + 16 * 5 + 512));
        Reset = 1'b1; step(); Reset = 1'b0;
        chk("reset_mid_dying_state", 32'(anim_state), 32'd0);
        chk("reset_mid_dying_addr", 32'(sprite_addr), 32'd261);
        repeat (20) step();
        chk("no_pulse_after_reset", 32'(done_seen), 32'd0);
        entity = 7'h7F; step();
        chk("unknown_entity_addr", 32'(sprite_addr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
